rvtu_mul_resp: RTL and testbench
================================

// Module: rvtu_mul_resp
// PURPOSE
//  Responder end of the RVTU multiply packet protocol. Pops two 36-bit request packets
//  {4b id, 32b data} from the execute stage's egress FIFO: operand A, then operand B
//  tagged with the op. Computes MUL/MULH/MULHSU/MULHU and pushes one result packet
//  {RESP_ID, 32b result} into its own 1-deep output FIFO. The execute stage reads that
//  FIFO through its ingress port. Exactly one operation is in flight at a time.
// PARAMETERS
//  packet1_id      5'd11  id of operand-A packet (low 4 bits used on the wire)
//  packet2_id_off  5'd12  id base of operand-B packet; id = 4'(packet2_id_off + op[1:0])
//  RESP_ID         4'd0   id placed in bits [35:32] of every result packet
//  LAT             2      cycles from operand-B capture to result enqueue; legal 1..8
// PORTS
//  clk        in   1   clock (single domain)
//  rst        in   1   synchronous, active-high reset
//  req_empty  in   1   requester egress FIFO empty
//  req_deq    out  1   pop requester egress FIFO (combinational)
//  req_pkt    in   36  head of requester egress FIFO; valid when ~req_empty
//  rsp_empty  out  1   result FIFO empty
//  rsp_deq    in   1   pop result FIFO (requester ingress)
//  rsp_pkt    out  36  head of result FIFO
//  proto_err  out  1   sticky: an unexpected packet id was popped and dropped
//  busy       out  1   state != WAIT_A
// BEHAVIOUR
//  - Reset: state=WAIT_A, result FIFO emptied (rsp_empty=1), proto_err=0, busy=0,
//    req_deq=0, latency counter=0. Reset mid-operation abandons the operation and
//    emits no result. Any pending rsp packet is discarded.
//  - FSM WAIT_A -> WAIT_B -> EXEC -> RESP -> WAIT_A. A state advances on one edge.
//  - WAIT_A: req_deq = ~req_empty.
//      id == 4'(packet1_id): capture data as opA, go to WAIT_B.
//      Any other id: drop the packet, set proto_err, stay in WAIT_A.
//  - WAIT_B: req_deq = ~req_empty.
//      id in {4'(packet2_id_off+k) | k=0..3}: capture data as opB and op = k.
//        The match uses 4-bit wrap-around, so the default ids are 12..15.
//        Load the counter with LAT-1 and go to EXEC.
//      id == 4'(packet1_id): replace opA, set proto_err, stay in WAIT_B.
//      Other id: drop the packet, set proto_err, stay in WAIT_B.
//  - EXEC, RESP: req_deq=0. No request is consumed while an op is in flight.
//  - EXEC: the counter decrements each cycle. At 0, go to RESP.
//      The multiplier result is registered and is stable no later than EXEC exit.
//  - RESP: enqueue {RESP_ID, result} when the result FIFO is not full, then go to WAIT_A.
//      If the FIFO is full, hold in RESP with the result held.
//      When the FIFO is empty, operand-B capture at edge N gives rsp_empty=0
//      after edge N+LAT+1.
//  - Arithmetic: 64-bit product of 33-bit sign/zero-extended operands.
//      op0 MUL    = prod[31:0] (signedness irrelevant)
//      op1 MULH   = prod[63:32], signed x signed
//      op2 MULHSU = prod[63:32], opA signed x opB unsigned
//      op3 MULHU  = prod[63:32], unsigned x unsigned
//  - Result FIFO: rsp_deq while empty is ignored.
//      Simultaneous enqueue and dequeue is legal in the same cycle; the FIFO full flag
//      must use the current dequeue.
//  - proto_err clears only on rst.
// STRUCTURE
//  - rv_pkg gains:
//      rvMulOp_t enum {MUL, MULH, MULHSU, MULHU} (2b, matches funct3[1:0])
//      typedef mulPkt_t struct packed {logic [3:0] id; logic [31:0] data;}
//  - Reuse the existing fifo sub-module for the result queue: DEPTH=1, WIDTH=36.
//  - One natural sub-module: rvtu_mul_core (33x33 signed multiply with LAT-stage
//    retiming pipeline, enable = EXEC).
// TESTING
//  1. Reset, then A=3 (id 11), B=0xFFFFFFFE (id 12)
//       -> rsp_pkt = {RESP_ID, 0xFFFFFFFA}; rsp_empty falls LAT+1 cycles after B pop.
//  2. MULH: A=B=0x80000000 (B id 13) -> 0x40000000.
//     MULHU: A=B=0xFFFFFFFF (id 15) -> 0xFFFFFFFE.
//  3. MULHSU: A=0xFFFFFFFF, B=0xFFFFFFFF (id 14) -> 0xFFFFFFFF.
//     MULHSU: A=2, B=0x80000000 -> 0x00000001.
//  4. Backpressure: hold rsp_deq=0 after op 1 and issue op 2.
//       -> FSM holds in RESP, req_deq stays 0, no packet is lost.
//       Then pulse rsp_deq -> second result appears next cycle.
//  5. Protocol error: id 12 popped in WAIT_A -> dropped, proto_err=1, still WAIT_A.
//       Then a normal op completes correctly.
//  6. Assert rst while in EXEC -> no result, rsp_empty=1, busy=0 next cycle.
//       A new op then works.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RVTU types for the multiply responder: op encoding, wire packet
// layout, responder FSM states and the latency counter width.
package rv_pkg;

    // Multiply op, encoded like funct3[1:0]
    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } rvMulOp_t;

    // One 36-bit packet on the request/response FIFOs
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
    } mulPkt_t;

    // Responder FSM states
    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } mulRespState_t;

    // Latency counter holds LAT-1, LAT is at most 8
    localparam int MUL_CNT_W = 3;

endpackage

// File: rtl/fifo.sv
// Small synchronous FIFO. 'full' already accounts for a dequeue in the
// same cycle, so a producer may push into a full FIFO while it drains.
module fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic [WIDTH-1:0] din,
    input  logic             deq,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_enq;
    logic             do_deq;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : AW'(p + 1'b1);
    endfunction

    assign empty  = (count == '0);
    assign do_deq = deq & ~empty;
    assign full   = (count == CW'(DEPTH)) & ~do_deq;
    assign do_enq = enq & ~full;
    assign dout   = mem[rd_ptr];

    // Occupancy and pointer bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_enq) wr_ptr <= next_ptr(wr_ptr);
            if (do_deq) rd_ptr <= next_ptr(rd_ptr);
            case ({do_enq, do_deq})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates them
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rvtu_mul_core.sv
// 33x33 signed multiplier with a LAT-deep retiming pipeline. Operands and op
// must stay stable while 'en' is high; after LAT enabled edges 'result' holds
// the selected 32-bit half and 'vld' is set. 'clr' restarts the valid chain.
module rvtu_mul_core
    import rv_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] result,
    output logic        vld
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod_p [LAT];
    rvMulOp_t           op_p   [LAT];
    logic [LAT-1:0]     vld_p;
    rvMulOp_t           op_in;

    // Sign- or zero-extend a 32-bit operand; the low 33 bits form the 33-bit operand
    function automatic logic signed [63:0] ext_operand(input logic [31:0] v, input logic sgn);
        return sgn ? {{32{v[31]}}, v} : {32'h0, v};
    endfunction

    // Pick the low word for MUL, the high word for the MULH variants
    function automatic logic [31:0] select_result(input logic signed [63:0] p, input rvMulOp_t o);
        return (o == MUL) ? p[31:0] : p[63:32];
    endfunction

    assign op_in = rvMulOp_t'(op);

    // Operand extension: A is signed unless MULHU, B is signed only for MULH
    always_comb begin
        a_ext = ext_operand(a, op_in != MULHU);
        b_ext = ext_operand(b, op_in == MULH);
    end

    // Product and op travel down the pipeline while enabled
    always_ff @(posedge clk) begin
        if (en) begin
            prod_p[0] <= a_ext * b_ext;
            op_p[0]   <= op_in;
            for (int i = 1; i < LAT; i++) begin
                prod_p[i] <= prod_p[i-1];
                op_p[i]   <= op_p[i-1];
            end
        end
    end

    // Valid chain alongside the product pipeline
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_p <= '0;
        end else if (en) begin
            vld_p[0] <= 1'b1;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign result = select_result(prod_p[LAT-1], op_p[LAT-1]);
    assign vld    = vld_p[LAT-1];

endmodule

// File: rtl/rvtu_mul_resp.sv
// Responder end of the RVTU multiply packet protocol: pops operand A, then
// operand B tagged with the op, multiplies, and queues one result packet.
// Only one operation is in flight at a time.
module rvtu_mul_resp
    import rv_pkg::*;
#(
    parameter logic [4:0] packet1_id     = 5'd11,
    parameter logic [4:0] packet2_id_off = 5'd12,
    parameter logic [3:0] RESP_ID        = 4'd0,
    parameter int         LAT            = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_empty,
    output logic        req_deq,
    input  logic [35:0] req_pkt,
    output logic        rsp_empty,
    input  logic        rsp_deq,
    output logic [35:0] rsp_pkt,
    output logic        proto_err,
    output logic        busy
);

    localparam logic [3:0] A_ID   = packet1_id[3:0];
    localparam logic [3:0] B_BASE = packet2_id_off[3:0];

    mulRespState_t          state;
    logic [MUL_CNT_W-1:0]   cnt;
    logic [31:0]            opa;
    logic [31:0]            opb;
    logic [1:0]             op;
    mulPkt_t                req;
    logic [3:0]             b_off;
    logic                   a_hit;
    logic                   b_hit;
    logic                   b_load;
    logic [31:0]            mul_result;
    logic                   mul_vld;
    logic                   rsp_full;
    logic                   rsp_enq;

    assign req   = mulPkt_t'(req_pkt);
    // B ids are matched modulo 16, so the offset from the base wraps too
    assign b_off = req.id - B_BASE;
    assign b_hit = (b_off[3:2] == 2'b00);
    assign a_hit = (req.id == A_ID);

    assign req_deq = ~rst & ~req_empty & ((state == WAIT_A) | (state == WAIT_B));
    assign b_load  = req_deq & (state == WAIT_B) & b_hit;
    assign rsp_enq = (state == RESP) & mul_vld & ~rsp_full;
    assign busy    = (state != WAIT_A);

    // Protocol FSM with latency counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_A;
            cnt       <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (req_deq) begin
                        if (a_hit) state     <= WAIT_B;
                        else       proto_err <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (req_deq) begin
                        if (b_hit) begin
                            cnt   <= MUL_CNT_W'(LAT - 1);
                            state <= EXEC;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                RESP: begin
                    if (rsp_enq) state <= WAIT_A;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

    // Operand capture; a repeated A packet in WAIT_B replaces operand A
    always_ff @(posedge clk) begin
        if (req_deq && state == WAIT_A && a_hit) begin
            opa <= req.data;
        end else if (req_deq && state == WAIT_B) begin
            if (b_hit) begin
                opb <= req.data;
                op  <= b_off[1:0];
            end else if (a_hit) begin
                opa <= req.data;
            end
        end
    end

    rvtu_mul_core #(
        .LAT(LAT)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (state == EXEC),
        .clr    (b_load),
        .a      (opa),
        .b      (opb),
        .op     (op),
        .result (mul_result),
        .vld    (mul_vld)
    );

    fifo #(
        .DEPTH(1),
        .WIDTH(36)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .enq   (rsp_enq),
        .din   ({RESP_ID, mul_result}),
        .deq   (rsp_deq),
        .dout  (rsp_pkt),
        .empty (rsp_empty),
        .full  (rsp_full)
    );

endmodule

// File: tb/tb_rvtu_mul_resp.sv
// Bench for rvtu_mul_resp: table of directed ops, hand-written multi-cycle
// sequences (backpressure, protocol errors, reset mid-op) and a randomized
// run scored against an arithmetic reference model.
module tb_rvtu_mul_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_empty;
    logic        req_deq;
    logic [35:0] req_pkt;
    logic        rsp_empty;
    logic        rsp_deq;
    logic [35:0] rsp_pkt;
    logic        proto_err;
    logic        busy;

    logic [35:0] req_q [$];
    logic [31:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;
    bit          auto_chk = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    rvtu_mul_resp #(
        .packet1_id     (5'd11),
        .packet2_id_off (5'd12),
        .RESP_ID        (4'd0),
        .LAT            (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_empty (req_empty),
        .req_deq   (req_deq),
        .req_pkt   (req_pkt),
        .rsp_empty (rsp_empty),
        .rsp_deq   (rsp_deq),
        .rsp_pkt   (rsp_pkt),
        .proto_err (proto_err),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on extended operands
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] pu;
        sa = (op == 2'd3) ? longint'({32'h0, a}) : longint'($signed(a));
        sb = (op == 2'd1) ? longint'($signed(b)) : longint'({32'h0, b});
        p  = sa * sb;
        pu = p;
        return (op == 2'd0) ? pu[31:0] : pu[63:32];
    endfunction

    function automatic void refresh();
        req_empty = (req_q.size() == 0);
        req_pkt   = req_empty ? 36'h0 : req_q[0];
    endfunction

    task automatic push(input logic [3:0] id, input logic [31:0] d);
        req_q.push_back({id, d});
        refresh();
    endtask

    // One clock: sample at negedge, update the requester FIFO model after the edge
    task automatic cycle();
        bit p;
        @(negedge clk);
        p = req_deq && !req_empty;
        if (auto_chk && rsp_deq && !rsp_empty) begin
            if (exp_q.size() == 0) check("rand_extra_rsp", rsp_pkt, 64'h0);
            else                   check("rand_result", rsp_pkt, {4'h0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
        if (p) void'(req_q.pop_front());
        refresh();
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_empty && n < 40) begin
            cycle();
            n++;
        end
    endtask

    task automatic pop_rsp(input string name);
        rsp_deq = 1'b1;
        cycle();
        rsp_deq = 1'b0;
        check({name, "_drained"}, rsp_empty, 1'b1);
    endtask

    // Full operation from idle: latency, packet contents, FSM back to idle
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        push(4'd11, a);
        push(4'(12 + op), b);
        wait_rsp(n);
        check({name, "_latency"}, n, LAT + 3);
        check({name, "_pkt"}, rsp_pkt, {4'h0, exp});
        check({name, "_idle"}, busy, 1'b0);
        pop_rsp(name);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0] = '{2'd0, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA};
        vt[1] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vt[2] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vt[3] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[4] = '{2'd2, 32'h00000002, 32'h80000000, 32'h00000001};
        vt[5] = '{2'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
        vt[6] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vt[7] = '{2'd0, 32'h12345678, 32'h00000010, 32'h23456780};

        rst     = 1'b1;
        rsp_deq = 1'b0;
        refresh();
        @(posedge clk);
        #1;
        push(4'd11, 32'h1);
        cycle();
        cycle();
        check("reset_req_deq", req_deq, 1'b0);
        check("reset_rsp_empty", rsp_empty, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_proto_err", proto_err, 1'b0);
        check("reset_no_pop", req_q.size(), 1);
        req_q.delete();
        refresh();
        rst = 1'b0;
        cycle();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp);
        end

        // Dequeue on an empty result FIFO is ignored
        rsp_deq = 1'b1;
        cycle();
        cycle();
        rsp_deq = 1'b0;
        check("deq_empty_ignored", rsp_empty, 1'b1);
        run_op("after_empty_deq", 2'd0, 32'd9, 32'd9, 32'd81);

        // Backpressure: two ops, result FIFO never drained
        push(4'd11, 32'd5);
        push(4'd12, 32'd7);
        push(4'd11, 32'hFFFFFFFF);
        push(4'd15, 32'd2);
        for (int i = 0; i < 20; i++) cycle();
        check("bp_busy_in_resp", busy, 1'b1);
        check("bp_req_deq_low", req_deq, 1'b0);
        check("bp_req_consumed", req_q.size(), 0);
        check("bp_first_pkt", rsp_pkt, {4'h0, 32'd35});
        rsp_deq = 1'b1;
        cycle();
        rsp_deq = 1'b0;
        check("bp_second_present", rsp_empty, 1'b0);
        check("bp_second_pkt", rsp_pkt, {4'h0, 32'd1});
        check("bp_idle", busy, 1'b0);
        pop_rsp("bp_second");

        // Protocol errors
        push(4'd12, 32'h1234);
        cycle();
        cycle();
        cycle();
        check("perr_set", proto_err, 1'b1);
        check("perr_wait_a", busy, 1'b0);
        check("perr_dropped", req_q.size(), 0);
        run_op("perr_recover", 2'd0, 32'd6, 32'd7, 32'd42);
        push(4'd11, 32'd100);
        push(4'd11, 32'd5);
        push(4'd3,  32'd99);
        push(4'd12, 32'd9);
        wait_rsp(n);
        check("perr_replace_a", rsp_pkt, {4'h0, 32'd45});
        check("perr_sticky", proto_err, 1'b1);
        pop_rsp("perr_replace");

        // Reset while executing
        push(4'd11, 32'd3);
        push(4'd12, 32'd4);
        cycle();
        cycle();
        check("rst_exec_busy", busy, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_exec_idle", busy, 1'b0);
        check("rst_exec_empty", rsp_empty, 1'b1);
        check("rst_clears_perr", proto_err, 1'b0);
        for (int i = 0; i < 6; i++) cycle();
        check("rst_exec_no_result", rsp_empty, 1'b1);
        run_op("after_rst", 2'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);

        // Randomized ops with random result backpressure
        auto_chk = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       rb = 32'h7FFFFFFF;
                1:       rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            push(4'd11, ra);
            push(4'(12 + rop), rb);
            exp_q.push_back(ref_mul(rop, ra, rb));
        end
        n = 0;
        while (exp_q.size() > 0 && n < 4000) begin
            rsp_deq = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        rsp_deq  = 1'b0;
        auto_chk = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_req_consumed", req_q.size(), 0);
        check("rand_no_perr", proto_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
